// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control sequencer and the datapath decoder.
// States, next-PC codes, instruction classes, exception codes and opcode/funct constants.
package ctrl_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned NPC_W   = 3;
  localparam int unsigned EXC_W   = 5;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned REG_W   = 5;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DECODE   = 3'd2,
    ST_EXEC     = 3'd3,
    ST_MEM      = 3'd4,
    ST_WB       = 3'd5,
    ST_INT      = 3'd6,
    ST_MDU_WAIT = 3'd7
  } state_t;

  typedef enum logic [NPC_W-1:0] {
    NPC_PC4    = 3'd0,
    NPC_BRANCH = 3'd1,
    NPC_JUMP   = 3'd2,
    NPC_GPR    = 3'd3,
    NPC_EPC    = 3'd4,
    NPC_EXC    = 3'd5
  } npc_t;

  typedef enum logic [3:0] {
    CLS_LOAD, CLS_STORE, CLS_ALU, CLS_MULT, CLS_DIV,
    CLS_BRANCH, CLS_JUMP, CLS_LINK, CLS_MOVE, CLS_ILLEGAL
  } class_t;

  localparam logic [EXC_W-1:0] EXC_INT = 5'd0;
  localparam logic [EXC_W-1:0] EXC_RI  = 5'd10;

  localparam logic [OP_W-1:0] OP_RTYPE  = 6'h00;
  localparam logic [OP_W-1:0] OP_REGIMM = 6'h01;
  localparam logic [OP_W-1:0] OP_J      = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL    = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ    = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE    = 6'h05;
  localparam logic [OP_W-1:0] OP_BLEZ   = 6'h06;
  localparam logic [OP_W-1:0] OP_BGTZ   = 6'h07;
  localparam logic [OP_W-1:0] OP_ADDI   = 6'h08;
  localparam logic [OP_W-1:0] OP_ADDIU  = 6'h09;
  localparam logic [OP_W-1:0] OP_SLTI   = 6'h0a;
  localparam logic [OP_W-1:0] OP_SLTIU  = 6'h0b;
  localparam logic [OP_W-1:0] OP_ANDI   = 6'h0c;
  localparam logic [OP_W-1:0] OP_ORI    = 6'h0d;
  localparam logic [OP_W-1:0] OP_XORI   = 6'h0e;
  localparam logic [OP_W-1:0] OP_LUI    = 6'h0f;
  localparam logic [OP_W-1:0] OP_COP0   = 6'h10;
  localparam logic [OP_W-1:0] OP_LB     = 6'h20;
  localparam logic [OP_W-1:0] OP_LH     = 6'h21;
  localparam logic [OP_W-1:0] OP_LW     = 6'h23;
  localparam logic [OP_W-1:0] OP_LBU    = 6'h24;
  localparam logic [OP_W-1:0] OP_LHU    = 6'h25;
  localparam logic [OP_W-1:0] OP_SB     = 6'h28;
  localparam logic [OP_W-1:0] OP_SH     = 6'h29;
  localparam logic [OP_W-1:0] OP_SW     = 6'h2b;

  localparam logic [OP_W-1:0] F_SLL   = 6'h00;
  localparam logic [OP_W-1:0] F_SRL   = 6'h02;
  localparam logic [OP_W-1:0] F_SRA   = 6'h03;
  localparam logic [OP_W-1:0] F_SLLV  = 6'h04;
  localparam logic [OP_W-1:0] F_SRLV  = 6'h06;
  localparam logic [OP_W-1:0] F_SRAV  = 6'h07;
  localparam logic [OP_W-1:0] F_JR    = 6'h08;
  localparam logic [OP_W-1:0] F_JALR  = 6'h09;
  localparam logic [OP_W-1:0] F_MFHI  = 6'h10;
  localparam logic [OP_W-1:0] F_MTHI  = 6'h11;
  localparam logic [OP_W-1:0] F_MFLO  = 6'h12;
  localparam logic [OP_W-1:0] F_MTLO  = 6'h13;
  localparam logic [OP_W-1:0] F_MULT  = 6'h18;
  localparam logic [OP_W-1:0] F_MULTU = 6'h19;
  localparam logic [OP_W-1:0] F_DIV   = 6'h1a;
  localparam logic [OP_W-1:0] F_DIVU  = 6'h1b;
  localparam logic [OP_W-1:0] F_ADD   = 6'h20;
  localparam logic [OP_W-1:0] F_ADDU  = 6'h21;
  localparam logic [OP_W-1:0] F_SUB   = 6'h22;
  localparam logic [OP_W-1:0] F_SUBU  = 6'h23;
  localparam logic [OP_W-1:0] F_AND   = 6'h24;
  localparam logic [OP_W-1:0] F_OR    = 6'h25;
  localparam logic [OP_W-1:0] F_XOR   = 6'h26;
  localparam logic [OP_W-1:0] F_NOR   = 6'h27;
  localparam logic [OP_W-1:0] F_SLT   = 6'h2a;
  localparam logic [OP_W-1:0] F_SLTU  = 6'h2b;
  localparam logic [OP_W-1:0] F_ERET  = 6'h18;

  localparam logic [REG_W-1:0] RT_BLTZ = 5'd0;
  localparam logic [REG_W-1:0] RT_BGEZ = 5'd1;
  localparam logic [REG_W-1:0] RS_MF   = 5'd0;
  localparam logic [REG_W-1:0] RS_MT   = 5'd4;
  localparam logic [REG_W-1:0] RS_CO   = 5'd16;

  // Branch condition from the ALU flags; REGIMM selects BLTZ/BGEZ by rt.
  function automatic logic br_taken(input logic [OP_W-1:0] op, input logic [REG_W-1:0] rt,
                                    input logic zero, input logic sign);
    logic t;
    t = 1'b0;
    case (op)
      OP_BEQ:    t = zero;
      OP_BNE:    t = ~zero;
      OP_BLEZ:   t = zero | sign;
      OP_BGTZ:   t = ~zero & ~sign;
      OP_REGIMM: t = (rt == RT_BGEZ) ? (zero | ~sign) : (sign & ~zero);
      default:   t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/mc_ctrl_seq_if.sv
// Instruction-field inputs and control-strobe outputs of the sequencer.
interface mc_ctrl_seq_if;
  logic [5:0] OP;
  logic [5:0] F;
  logic [4:0] RT;
  logic [4:0] RS;
  logic       Zero;
  logic       Sign;
  logic       IntReq;
  logic       EXL;
  logic       DMReady;
  logic [2:0] State;
  logic [2:0] NPCOp;
  logic       PCWr;
  logic       IRWr;
  logic       GPRWr;
  logic       DMReq;
  logic       DMWr;
  logic       LOWr;
  logic       HIWr;
  logic       CP0Wr;
  logic       CP0CLRWr;
  logic       MDUStart;
  logic       EXLSet;
  logic [4:0] ExcCode;

  modport slave (
    input  OP, F, RT, RS, Zero, Sign, IntReq, EXL, DMReady,
    output State, NPCOp, PCWr, IRWr, GPRWr, DMReq, DMWr, LOWr, HIWr,
           CP0Wr, CP0CLRWr, MDUStart, EXLSet, ExcCode
  );

  modport master (
    output OP, F, RT, RS, Zero, Sign, IntReq, EXL, DMReady,
    input  State, NPCOp, PCWr, IRWr, GPRWr, DMReq, DMWr, LOWr, HIWr,
           CP0Wr, CP0CLRWr, MDUStart, EXLSet, ExcCode
  );
endinterface

// File: rtl/ctrl_class_dec.sv
// Combinational instruction-field to class decoder, shared with the datapath decoder.
module ctrl_class_dec
  import ctrl_pkg::*;
(
  input  logic [OP_W-1:0]  op,
  input  logic [OP_W-1:0]  f,
  input  logic [REG_W-1:0] rt,
  input  logic [REG_W-1:0] rs,
  output class_t           cls
);

  always_comb begin
    cls = CLS_ILLEGAL;
    case (op)
      OP_RTYPE: begin
        case (f)
          F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV,
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
          F_SLT, F_SLTU:                   cls = CLS_ALU;
          F_JR:                            cls = CLS_JUMP;
          F_JALR:                          cls = CLS_LINK;
          F_MFHI, F_MTHI, F_MFLO, F_MTLO:  cls = CLS_MOVE;
          F_MULT, F_MULTU:                 cls = CLS_MULT;
          F_DIV, F_DIVU:                   cls = CLS_DIV;
          default:                         cls = CLS_ILLEGAL;
        endcase
      end
      OP_REGIMM: cls = (rt == RT_BLTZ || rt == RT_BGEZ) ? CLS_BRANCH : CLS_ILLEGAL;
      OP_J:      cls = CLS_JUMP;
      OP_JAL:    cls = CLS_LINK;
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: cls = CLS_BRANCH;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: cls = CLS_ALU;
      OP_COP0: begin
        if (rs == RS_MF || rs == RS_MT)      cls = CLS_MOVE;
        else if (rs == RS_CO && f == F_ERET) cls = CLS_JUMP;
        else                                 cls = CLS_ILLEGAL;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: cls = CLS_LOAD;
      OP_SB, OP_SH, OP_SW:                 cls = CLS_STORE;
      default:                             cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_seq.sv
// Multi-cycle control sequencer: state register plus combinational strobes and next-PC select.
// Optional reserved-instruction exception enabled by defining CTRL_RI_EXC_EN.
module mc_ctrl_seq
  import ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 3,
  parameter int unsigned DIV_CYCLES  = 17
) (
  input logic         clk,
  input logic         rst,
  mc_ctrl_seq_if.slave bus
);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  class_t             cls;
  npc_t               npc;
  logic [EXC_W-1:0]   exc_code;
  logic pc_wr, ir_wr, gpr_wr, dm_req, dm_wr, lo_wr, hi_wr, cp0_wr, cp0_clr_wr, mdu_start, exl_set;
`ifdef CTRL_RI_EXC_EN
  logic ri_flag, ri_nx;
`endif

  ctrl_class_dec u_dec (
    .op  (bus.OP),
    .f   (bus.F),
    .rt  (bus.RT),
    .rs  (bus.RS),
    .cls (cls)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
`ifdef CTRL_RI_EXC_EN
      ri_flag <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
`ifdef CTRL_RI_EXC_EN
      ri_flag <= ri_nx;
`endif
    end
  end

  // Next state and all strobes; anything not set below stays 0.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    npc        = NPC_PC4;
    exc_code   = EXC_INT;
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    gpr_wr     = 1'b0;
    dm_req     = 1'b0;
    dm_wr      = 1'b0;
    lo_wr      = 1'b0;
    hi_wr      = 1'b0;
    cp0_wr     = 1'b0;
    cp0_clr_wr = 1'b0;
    mdu_start  = 1'b0;
    exl_set    = 1'b0;
`ifdef CTRL_RI_EXC_EN
    ri_nx      = ri_flag;
`endif
    case (state)
      ST_IDLE: state_nx = ST_FETCH;
      ST_FETCH: begin
        ir_wr    = 1'b1;
        state_nx = ST_DECODE;
      end
      ST_DECODE: begin
        state_nx = ST_EXEC;
        if (cls == CLS_JUMP) begin
          pc_wr    = 1'b1;
          state_nx = ST_INT;
          if (bus.OP == OP_J) npc = NPC_JUMP;
          else if (bus.OP == OP_COP0) begin
            npc        = NPC_EPC;
            cp0_clr_wr = 1'b1;
          end else npc = NPC_GPR;
        end else if (cls == CLS_LINK) begin
          gpr_wr = 1'b1;
        end
      end
      ST_EXEC: begin
        state_nx = ST_INT;
        case (cls)
          CLS_BRANCH: begin
            pc_wr = 1'b1;
            npc   = br_taken(bus.OP, bus.RT, bus.Zero, bus.Sign) ? NPC_BRANCH : NPC_PC4;
          end
          CLS_LINK: begin
            pc_wr = 1'b1;
            npc   = (bus.OP == OP_JAL) ? NPC_JUMP : NPC_GPR;
          end
          CLS_MOVE: begin
            pc_wr  = 1'b1;
            gpr_wr = (bus.OP == OP_RTYPE && (bus.F == F_MFHI || bus.F == F_MFLO)) ||
                     (bus.OP == OP_COP0 && bus.RS == RS_MF);
            hi_wr  = (bus.OP == OP_RTYPE && bus.F == F_MTHI);
            lo_wr  = (bus.OP == OP_RTYPE && bus.F == F_MTLO);
            cp0_wr = (bus.OP == OP_COP0 && bus.RS == RS_MT);
          end
          CLS_MULT: begin
            mdu_start = 1'b1;
            cnt_nx    = CNT_W'(MULT_CYCLES - 1);
            state_nx  = ST_MDU_WAIT;
          end
          CLS_DIV: begin
            mdu_start = 1'b1;
            cnt_nx    = CNT_W'(DIV_CYCLES - 1);
            state_nx  = ST_MDU_WAIT;
          end
          CLS_LOAD, CLS_STORE, CLS_ALU: state_nx = ST_MEM;
          CLS_ILLEGAL: begin
`ifdef CTRL_RI_EXC_EN
            ri_nx = 1'b1;
`else
            pc_wr = 1'b1;
`endif
          end
          default: state_nx = ST_INT;
        endcase
      end
      ST_MDU_WAIT: begin
        if (cnt == '0) begin
          hi_wr    = 1'b1;
          lo_wr    = 1'b1;
          pc_wr    = 1'b1;
          state_nx = ST_INT;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      ST_MEM: begin
        state_nx = ST_INT;
        case (cls)
          CLS_ALU: begin
            gpr_wr = 1'b1;
            pc_wr  = 1'b1;
          end
          CLS_STORE: begin
            dm_req = 1'b1;
            dm_wr  = 1'b1;
            pc_wr  = bus.DMReady;
            state_nx = bus.DMReady ? ST_INT : ST_MEM;
          end
          CLS_LOAD: begin
            dm_req   = 1'b1;
            state_nx = bus.DMReady ? ST_WB : ST_MEM;
          end
          default: state_nx = ST_INT;
        endcase
      end
      ST_WB: begin
        gpr_wr   = 1'b1;
        pc_wr    = 1'b1;
        state_nx = ST_INT;
      end
      ST_INT: begin
        state_nx = ST_FETCH;
        // A pending reserved-instruction trap wins over the interrupt and ignores EXL.
`ifdef CTRL_RI_EXC_EN
        ri_nx = 1'b0;
        if (ri_flag) begin
          exl_set  = 1'b1;
          pc_wr    = 1'b1;
          npc      = NPC_EXC;
          exc_code = EXC_RI;
        end else
`endif
        if (bus.IntReq && !bus.EXL) begin
          exl_set  = 1'b1;
          pc_wr    = 1'b1;
          npc      = NPC_EXC;
          exc_code = EXC_INT;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign bus.State    = state;
  assign bus.NPCOp    = npc;
  assign bus.ExcCode  = exc_code;
  assign bus.PCWr     = pc_wr;
  assign bus.IRWr     = ir_wr;
  assign bus.GPRWr    = gpr_wr;
  assign bus.DMReq    = dm_req;
  assign bus.DMWr     = dm_wr;
  assign bus.LOWr     = lo_wr;
  assign bus.HIWr     = hi_wr;
  assign bus.CP0Wr    = cp0_wr;
  assign bus.CP0CLRWr = cp0_clr_wr;
  assign bus.MDUStart = mdu_start;
  assign bus.EXLSet   = exl_set;

endmodule

// File: doc/mc_ctrl_seq.md
# mc_ctrl_seq

Parametrised multi-cycle control sequencer for the MIPS-subset core. It replaces the fixed-count controller with an explicit state machine. Over that controller it adds reset, memory wait-state handshaking, separately parametrised multiply and divide latencies, and an optional reserved-instruction exception. It sits between the instruction register (OP/F/RT/RS) and the datapath write enables and next-PC selection. Datapath mux selects (WDSel, BSel, ALUOp, …) remain with the datapath decoder.

## Interface
- MULT_CYCLES, 3: MDU_WAIT cycles for MULT/MULTU; legal range 1..32
- DIV_CYCLES, 17: MDU_WAIT cycles for DIV/DIVU; legal range 1..32
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- OP, F  in  6 each  opcode / funct fields
- RT, RS  in  5 each  rt / rs fields
- Zero, Sign  in  1 each  ALU flags, valid in EXEC
- IntReq  in  1  external interrupt request, level
- EXL  in  1  CP0 status EXL bit
- DMReady  in  1  data memory completes the access this cycle
- State  out  3  current state encoding
- NPCOp  out  3  next-PC select: 0 PC+4, 1 branch, 2 jump target, 3 GPR[rs], 4 EPC, 5 exception vector
- PCWr, IRWr, GPRWr, DMReq, DMWr, LOWr, HIWr, CP0Wr, CP0CLRWr  out  1 each  write and request strobes
- MDUStart  out  1  one-cycle multiply/divide launch
- EXLSet  out  1  exception or interrupt entry strobe
- ExcCode  out  5  0 = interrupt, 10 = reserved instruction

## Operation
- The `ctrl_class_dec` decoder maps the instruction fields to one class: LOAD, STORE, ALU, MULT, DIV, BRANCH, JUMP (J, JR, ERET), LINK (JAL, JALR), MOVE (MFHI, MFLO, MTHI, MTLO, MFC0, MTC0), or ILLEGAL.
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, INT=6, MDU_WAIT=7.
- IDLE → FETCH unconditionally.
- FETCH: IRWr=1. Next state DECODE.
- DECODE, JUMP: PCWr=1, NPCOp=2 (J), 3 (JR) or 4 (ERET). ERET also drives CP0CLRWr=1. Next state INT.
- DECODE, LINK: GPRWr=1. Next state EXEC.
- DECODE, all other classes: next state EXEC.
- EXEC, BRANCH: PCWr=1. NPCOp=1 when the condition holds, else 0.
  - BEQ: Zero. BNE: ~Zero. BLEZ: Zero|Sign. BGTZ: ~Zero&~Sign. BLTZ: Sign&~Zero. BGEZ: Zero|~Sign.
  - Next state INT.
- EXEC, LINK: PCWr=1, NPCOp=2 (JAL) or 3 (JALR). Next state INT.
- EXEC, MOVE: PCWr=1. GPRWr for MF*; HIWr for MTHI, LOWr for MTLO, CP0Wr for MTC0. Next state INT.
- EXEC, MULT/DIV: MDUStart=1. Load the counter with the class latency minus 1. Next state MDU_WAIT.
- EXEC, LOAD/STORE/ALU: next state MEM.
- EXEC, ILLEGAL: see Configuration.
- MDU_WAIT: counter decrements each cycle. At 0: HIWr=LOWr=PCWr=1, next state INT.
- MEM, ALU: GPRWr=PCWr=1. Next state INT.
- MEM, STORE: DMReq=DMWr=1. Hold MEM until DMReady; in the DMReady cycle PCWr=1, next state INT.
- MEM, LOAD: DMReq=1. Hold until DMReady, then next state WB.
- WB: GPRWr=PCWr=1. Next state INT.
- INT:
  - IntReq&~EXL: EXLSet=PCWr=1, NPCOp=5, ExcCode=0.
  - Pending reserved-instruction flag: EXLSet=PCWr=1, NPCOp=5, ExcCode=10. This is taken regardless of EXL and has priority over the interrupt.
  - Next state FETCH.
- Unlisted state/class combinations drive every strobe to 0 and NPCOp to 0.

## Timing
- All outputs are combinational from State, the registered counter and the current inputs. There is no output register.
- Reset: State=IDLE, counter=0, RI flag=0. Every strobe is 0, NPCOp=0, ExcCode=0.
- Reset asserted mid-instruction aborts the instruction immediately. A pending MDU result is discarded and no write strobe fires.
- Latencies in cycles, FETCH through INT inclusive:
  - JUMP: 3
  - BRANCH, LINK, MOVE: 4
  - ALU: 5
  - STORE: 5 + store wait cycles
  - LOAD: 6 + load wait cycles
  - MULT/DIV: 4 + latency
- Each wait cycle is a MEM cycle with DMReady=0.
- DMReady outside MEM is ignored. DMReq stays high continuously through a wait.
- IntReq arriving during a DMReady wait is taken only in INT.
- The counter is 5 bits.

## Configuration
- CTRL_RI_EXC_EN defined: ILLEGAL in EXEC sets the RI flag and goes to INT with no PC write. INT then takes the reserved-instruction exception. The flag clears in INT.
- CTRL_RI_EXC_EN undefined: ILLEGAL in EXEC behaves as a NOP (PCWr=1, NPCOp=0, next state INT). ExcCode is never 10.

## Structure
- Package `ctrl_pkg` holds:
  - state encodings
  - NPCOp codes
  - the class enumeration
  - ExcCode constants
  - opcode/funct constants
- Sub-module `ctrl_class_dec`: purely combinational field-to-class decoder, shared with the datapath decoder.

## Test plan
- Reset mid-MEM of a LOAD (LW, DMReady=0): State=0 and every strobe 0 in the same cycle; FETCH one cycle after release.
- ADDU: exactly 5 cycles. IRWr in FETCH; GPRWr+PCWr in MEM; no DMReq.
- SW with DMReady low for 3 cycles: DMReq/DMWr high for 4 MEM cycles; PCWr only in the 4th.
- DIV with DIV_CYCLES=17: one MDUStart pulse; HIWr/LOWr/PCWr together exactly 17 cycles later; total 21 cycles.
- BNE with Zero=1 → NPCOp=0; repeated with Zero=0 → NPCOp=1; PCWr=1 in EXEC both times.
- IntReq=1, EXL=0 during an ADD: EXLSet, NPCOp=5, ExcCode=0 in INT. With EXL=1: no EXLSet.
- OP=6'b111111 with CTRL_RI_EXC_EN: ExcCode=10, EXLSet in INT. Without the macro: PCWr in EXEC, no EXLSet.
